// File: rtl/context_table.sv
// Per-program resume-address table with round-robin restore search.
// Slots 1..NPROG hold a live bit and a relative address; a restore search scans from last_prog+1.
`timescale 1ns/1ps
module context_table #(
    parameter int NPROG  = 5,
    parameter int OFFSET = 1000,
    parameter int AW     = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          save,
    input  logic [2:0]    save_prog,
    input  logic [AW-1:0] save_addr,
    input  logic          end_valid,
    input  logic [2:0]    end_prog,
    input  logic          restore_req,
    output logic          restore_valid,
    output logic [2:0]    restore_prog,
    output logic [AW-1:0] restore_addr,
    output logic          busy,
    output logic          all_done,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_GRANT = 2'd2} state_t;

    localparam logic [2:0] NP = 3'(NPROG);

    state_t        r_state;
    state_t        w_state_next;
    logic [NPROG:1] r_live;
    logic [NPROG:1] w_live_next;
    logic [AW-1:0] r_addr [1:NPROG];
    logic [2:0]    r_last;
    logic [2:0]    r_cand;
    logic [2:0]    r_cnt;
    logic [2:0]    r_restore_prog;
    logic [AW-1:0] r_restore_addr;
    logic          r_all_done;

    logic          w_save_ok;
    logic          w_end_ok;
    logic          w_end_same;
    logic [AW-1:0] w_save_rel;
    logic          w_cand_live;
    logic [AW-1:0] w_cand_addr;
    logic          w_last_check;
    logic [2:0]    w_cand_next;
    logic [2:0]    w_cand_start;

    assign w_save_ok    = save && (save_prog != 3'd0) && (save_prog <= NP);
    assign w_end_ok     = end_valid && (end_prog != 3'd0) && (end_prog <= NP);
    assign w_end_same   = w_end_ok && (end_prog == save_prog);
    assign w_save_rel   = save_addr - (AW'(save_prog) * AW'(OFFSET));
    assign w_last_check = (r_cnt == NP - 3'd1);
    assign w_cand_next  = (r_cand == NP) ? 3'd1 : r_cand + 3'd1;
    assign w_cand_start = (r_last == NP) ? 3'd1 : r_last + 3'd1;

    always_comb begin
        w_live_next = r_live;
        for (int i = 1; i <= NPROG; i++) begin
            if (w_end_ok && end_prog == 3'(i)) w_live_next[i] = 1'b0;
        end
    end

    always_comb begin
        w_cand_live = 1'b0;
        w_cand_addr = '0;
        for (int i = 1; i <= NPROG; i++) begin
            if (r_cand == 3'(i)) begin
                w_cand_live = r_live[i];
                w_cand_addr = r_addr[i];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (restore_req) w_state_next = S_SEARCH;
            S_SEARCH: if (w_cand_live || w_last_check) w_state_next = S_GRANT;
            S_GRANT:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Outputs; the grant pulse is masked during reset so an aborted grant never shows
    always_comb begin
        busy          = (r_state == S_SEARCH);
        restore_valid = (r_state == S_GRANT) && reset;
        o_dbg_state   = r_state;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_live         <= '1;
            r_last         <= NP;
            r_cand         <= 3'd0;
            r_cnt          <= 3'd0;
            r_restore_prog <= 3'd0;
            r_restore_addr <= '0;
            r_all_done     <= 1'b0;
            for (int i = 1; i <= NPROG; i++) r_addr[i] <= '0;
        end else begin
            r_live     <= w_live_next;
            r_all_done <= ~|w_live_next;
            // A simultaneous end on the same slot suppresses the address write
            for (int i = 1; i <= NPROG; i++) begin
                if (w_save_ok && !w_end_same && save_prog == 3'(i)) r_addr[i] <= w_save_rel;
            end
            case (r_state)
                S_IDLE: begin
                    if (restore_req) begin
                        r_cand <= w_cand_start;
                        r_cnt  <= 3'd0;
                    end
                end
                S_SEARCH: begin
                    if (w_cand_live) begin
                        r_restore_prog <= r_cand;
                        r_restore_addr <= w_cand_addr;
                        r_last         <= r_cand;
                    end else if (w_last_check) begin
                        r_restore_prog <= 3'd0;
                        r_restore_addr <= '0;
                    end else begin
                        r_cand <= w_cand_next;
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign restore_prog = r_restore_prog;
    assign restore_addr = r_restore_addr;
    assign all_done     = r_all_done;

endmodule

// File: doc/context_table.md
CONTEXT_TABLE -- requirements
Module: context_table

Interface
REQ-001 The block SHALL have these parameters: NPROG, 5, number of user program slots (ids 1..NPROG); OFFSET, 1000, address base stride per program; AW, 32, address width.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 save  input  1  one-cycle pulse: store the resume address of save_prog.
REQ-005 save_prog  input  3  program id being preempted.
REQ-006 save_addr  input  AW  absolute resume address (already incremented by the PC).
REQ-007 end_valid  input  1  one-cycle pulse: program end_prog has finished.
REQ-008 end_prog  input  3  id of the finished program.
REQ-009 restore_req  input  1  one-cycle pulse: request the next program to run.
REQ-010 restore_valid  output  1  one-cycle pulse: restore_prog and restore_addr are valid.
REQ-011 restore_prog  output  3  granted program id; 0 means no live program.
REQ-012 restore_addr  output  AW  relative resume address of restore_prog (PC adds restore_prog*OFFSET).
REQ-013 busy  output  1  high while a restore search is in progress.
REQ-014 all_done  output  1  registered; high when no slot is live.

Function
REQ-015 Each slot 1..NPROG SHALL hold a live bit and an AW-bit relative address; a last_prog register SHALL hold the most recently granted id.
REQ-016 On save with 1<=save_prog<=NPROG, slot[save_prog].addr SHALL be written at the edge with (save_addr - save_prog*OFFSET) truncated to AW bits (modulo 2^AW, no underflow check).
REQ-017 save or end_valid with id 0 or id >NPROG SHALL be ignored with no state change.
REQ-018 On end_valid with a legal id, slot[end_prog].live SHALL be cleared at the edge.
REQ-019 If save and end_valid target the same slot in one cycle, end SHALL win: live cleared, addr unchanged.
REQ-020 The FSM SHALL have states IDLE, SEARCH, GRANT; reset state is IDLE.
REQ-021 IDLE: restore_req SHALL move to SEARCH, set the candidate to (last_prog mod NPROG)+1 and the check counter to 0; busy SHALL be high from the following cycle.
REQ-022 SEARCH: one candidate SHALL be checked per edge; if live, restore_prog/restore_addr SHALL be loaded from it, last_prog updated, state to GRANT; otherwise the candidate SHALL advance with wrap NPROG->1 and the counter SHALL increment.
REQ-023 SEARCH: after NPROG non-live checks the FSM SHALL go to GRANT with restore_prog=0, restore_addr=0, last_prog unchanged.
REQ-024 GRANT: restore_valid SHALL be high for exactly one cycle, busy low, then IDLE.
REQ-025 Latency: if the k-th candidate (k=1..NPROG) is the first live one, restore_valid SHALL be high in the cycle following the k-th edge after the restore_req edge; the worst case is NPROG+1 cycles.
REQ-026 restore_req while busy or in GRANT SHALL be ignored and not queued.
REQ-027 save and end_valid SHALL be accepted in every state; a slot checked at a later edge SHALL see the update.
REQ-028 all_done SHALL be updated every edge from the post-update live bits.
REQ-029 restore_prog and restore_addr SHALL hold their values until the next grant.

Reset
REQ-030 On a clock edge with reset=0, the block SHALL set all live bits to 1, all addrs to 0, last_prog=NPROG, state=IDLE, restore_valid=0, restore_prog=0, restore_addr=0, busy=0, all_done=0; other inputs on that edge SHALL be ignored.
REQ-031 Reset asserted mid-SEARCH or mid-GRANT SHALL abort the search with no restore_valid pulse.

Verification
REQ-032 After reset, restore_req -> restore_valid one cycle after the next edge with prog=1, addr=0; repeated requests yield 2,3,4,5,1.
REQ-033 save prog=3, addr=3007; last_prog=2; restore_req -> prog=3, addr=7.
REQ-034 end_valid for 2,3,4; last_prog=1; restore_req -> prog=5 after 4 search edges, busy high for 4 cycles.
REQ-035 end_valid for all 5 ids -> all_done=1; restore_req -> restore_valid after 5 search edges with prog=0, addr=0.
REQ-036 save and end_valid for prog=4 in the same cycle -> slot 4 not live and addr unchanged; a restore_req during busy -> no second grant.
REQ-037 reset=0 asserted during SEARCH -> no restore_valid; all slots live; the next restore grants prog=1.
